// File: rtl/axis_burst_capture_if.sv
// Stream bundle shared by the capture input and FIFO-side output of axis_burst_capture.
interface axis_burst_capture_if #(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tlast;
  logic                  tvalid;
  logic                  tfull;

  modport master (output tdata, tuser, tlast, tvalid, input tfull);
  modport slave  (input tdata, tuser, tlast, tvalid, output tfull);
endinterface

// File: rtl/axis_burst_capture.sv
// Arm/trigger burst capture feeding a stream FIFO; drops and counts samples while the FIFO is full.
// Optional decimation is built only when AXIS_BURST_CAPTURE_DECIMATION_EN is defined.
module axis_burst_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  axis_burst_capture_if.slave   s_axis_in,
  axis_burst_capture_if.master  m_axis_out,
  input  logic                  arm_i,
  input  logic                  trigger_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [7:0]            decim_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           overflow_cnt_o
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] last_slot;
  logic [LEN_WIDTH-1:0] slot_cnt;
  logic [LEN_WIDTH-1:0] cur_slot;
  logic                 cap_active;
  logic                 phase_hit;
  logic                 take;
  logic                 at_last;
  logic                 unused_in;

  // The source cannot be stalled.
  assign s_axis_in.tfull = 1'b0;

  // The trigger cycle behaves as a CAPTURE cycle with counters already cleared.
  always_comb begin
    cap_active = (state == CAPTURE) || ((state == ARMED) && trigger_i);
    cur_slot   = (state == CAPTURE) ? slot_cnt : '0;
    take       = cap_active && s_axis_in.tvalid && phase_hit;
    at_last    = (cur_slot == last_slot);
  end

`ifdef AXIS_BURST_CAPTURE_DECIMATION_EN
  logic [7:0] decim_q;
  logic [7:0] phase_cnt;
  logic [7:0] cur_phase;

  always_comb begin
    cur_phase = (state == CAPTURE) ? phase_cnt : '0;
    phase_hit = (cur_phase == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      decim_q   <= '0;
      phase_cnt <= '0;
    end else begin
      if ((state == IDLE) && arm_i && (len_i != '0))
        decim_q <= decim_i;
      if (cap_active && s_axis_in.tvalid)
        phase_cnt <= (cur_phase == decim_q) ? '0 : cur_phase + 8'd1;
    end
  end

  assign unused_in = ^{s_axis_in.tuser, s_axis_in.tlast};
`else
  assign phase_hit = 1'b1;
  assign unused_in = ^{s_axis_in.tuser, s_axis_in.tlast, decim_i};
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state             <= IDLE;
      last_slot         <= '0;
      slot_cnt          <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      overflow_cnt_o    <= '0;
      m_axis_out.tdata  <= '0;
      m_axis_out.tuser  <= '0;
      m_axis_out.tlast  <= 1'b0;
      m_axis_out.tvalid <= 1'b0;
    end else begin
      m_axis_out.tvalid <= 1'b0;
      m_axis_out.tuser  <= '0;
      m_axis_out.tlast  <= 1'b0;
      done_o            <= 1'b0;
      case (state)
        IDLE: begin
          if (arm_i && (len_i != '0)) begin
            state     <= ARMED;
            last_slot <= len_i - 1'b1;
            busy_o    <= 1'b1;
          end
        end
        ARMED, CAPTURE: begin
          if (cap_active) begin
            state    <= CAPTURE;
            slot_cnt <= cur_slot;
            if (take) begin
              if (!m_axis_out.tfull) begin
                m_axis_out.tvalid   <= 1'b1;
                m_axis_out.tdata    <= s_axis_in.tdata;
                m_axis_out.tuser[0] <= (cur_slot == '0);
                m_axis_out.tlast    <= at_last;
              end else if (overflow_cnt_o != '1) begin
                overflow_cnt_o <= overflow_cnt_o + 16'd1;
              end
              if (at_last) begin
                state  <= IDLE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end else begin
                slot_cnt <= cur_slot + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_burst_capture.sv
// Scoreboard bench for axis_burst_capture: directed scenarios plus randomized bursts.
module tb_axis_burst_capture;
  localparam int DW = 16;
  localparam int UW = 1;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset_ni;
  logic          arm_i;
  logic          trigger_i;
  logic [LW-1:0] len_i;
  logic [7:0]    decim_i;
  logic          busy_o;
  logic          done_o;
  logic [15:0]   overflow_cnt_o;

  axis_burst_capture_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s_axis_in ();
  axis_burst_capture_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m_axis_out ();

  axis_burst_capture #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .LEN_WIDTH(LW)) dut (
    .clk_i          (clk),
    .reset_ni       (reset_ni),
    .s_axis_in      (s_axis_in.slave),
    .m_axis_out     (m_axis_out.master),
    .arm_i          (arm_i),
    .trigger_i      (trigger_i),
    .len_i          (len_i),
    .decim_i        (decim_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .overflow_cnt_o (overflow_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    bit            first;
    bit            last;
    int unsigned   cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned done_q[$];
  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned ovf_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_tvalid", {31'd0, m_axis_out.tvalid}, 0);
    check("rst_tdata", {16'd0, m_axis_out.tdata}, 0);
    check("rst_tuser", {31'd0, m_axis_out.tuser[0]}, 0);
    check("rst_tlast", {31'd0, m_axis_out.tlast}, 0);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_done", {31'd0, done_o}, 0);
    check("rst_ovf", {16'd0, overflow_cnt_o}, 0);
  endtask

  // Monitor: every output strobe or done pulse is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_axis_out.tvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tvalid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_cycle", cyc, e.cyc);
          check("tdata", {16'd0, m_axis_out.tdata}, {16'd0, e.data});
          check("tuser", {31'd0, m_axis_out.tuser[0]}, {31'd0, e.first});
          check("tlast", {31'd0, m_axis_out.tlast}, {31'd0, e.last});
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("missing_tvalid", 0, 1);
      end
      if (done_o === 1'b1) begin
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else check("done_cycle", cyc, done_q.pop_front());
      end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
        void'(done_q.pop_front());
        check("missing_done", 0, 1);
      end
    end
  end

  // Reference: among valid samples after the trigger, every (decim+1)-th one is a slot;
  // slot k is emitted one cycle later unless the FIFO is full that cycle.
  task automatic run_burst(input int unsigned len, input int unsigned dec, input int unsigned pv,
                           input bit alt, input int unsigned pf, input int full_slot,
                           input int rst_slot, input int unsigned delay, input logic [DW-1:0] base);
    int unsigned eff;
    int unsigned vcnt;
    int unsigned i;
    int unsigned k;
    bit          vld;
    bit          fullv;
    bit          finished;
    bit          was_reset;
    exp_t        e;
`ifdef AXIS_BURST_CAPTURE_DECIMATION_EN
    eff = dec;
`else
    eff = 0;
`endif
    arm_i = 1'b1; len_i = LW'(len); decim_i = 8'(dec); trigger_i = 1'b0;
    s_axis_in.tvalid = 1'($urandom); s_axis_in.tdata = DW'($urandom);
    tick();
    arm_i = 1'b0; len_i = LW'($urandom); decim_i = 8'($urandom);
    check("busy_armed", {31'd0, busy_o}, 1);
    for (int unsigned j = 0; j < delay; j++) begin
      s_axis_in.tvalid = 1'($urandom); s_axis_in.tdata = DW'($urandom);
      m_axis_out.tfull = 1'($urandom);
      tick();
    end
    vcnt = 0; i = 0; finished = 0; was_reset = 0;
    while (!finished) begin
      trigger_i = (i == 0) ? 1'b1 : ($urandom % 4 == 0);
      arm_i     = (i > 0) && ($urandom % 4 == 0);
      len_i     = LW'($urandom_range(1, 20));
      vld   = alt ? (i % 2 == 0) : ($urandom % 100 < pv);
      fullv = ($urandom % 100 < pf);
      if (vld && (vcnt % (eff + 1) == 0)) begin
        k = vcnt / (eff + 1);
        if (int'(k) == full_slot) fullv = 1'b1;
        if (int'(k) == rst_slot) begin
          reset_ni = 1'b0;
          was_reset = 1;
        end else begin
          if (fullv) begin
            if (ovf_exp < 16'hFFFF) ovf_exp++;
          end else begin
            e.data = base + DW'(i); e.first = (k == 0); e.last = (k == len - 1); e.cyc = cyc + 1;
            exp_q.push_back(e);
          end
          if (k == len - 1) begin
            done_q.push_back(cyc + 1);
          end
        end
        if (was_reset || k == len - 1) finished = 1;
      end
      if (vld) vcnt++;
      s_axis_in.tvalid = vld; s_axis_in.tdata = base + DW'(i); m_axis_out.tfull = fullv;
      tick();
      i++;
      if (!finished && i > 20000) begin
        check("burst_cycle_bound", 0, 1);
        finished = 1;
      end
    end
    arm_i = 1'b0; trigger_i = 1'b0; s_axis_in.tvalid = 1'b0; m_axis_out.tfull = 1'b0;
    if (was_reset) begin
      check_reset_values();
      ovf_exp = 0;
      reset_ni = 1'b1;
    end else begin
      check("busy_after_burst", {31'd0, busy_o}, 0);
      check("overflow_cnt", {16'd0, overflow_cnt_o}, ovf_exp);
    end
    tick();
  endtask

  initial begin
    reset_ni = 1'b0; arm_i = 1'b0; trigger_i = 1'b0; len_i = '0; decim_i = '0;
    s_axis_in.tdata = '0; s_axis_in.tvalid = 1'b0; s_axis_in.tuser = '0; s_axis_in.tlast = 1'b0;
    m_axis_out.tfull = 1'b0;
    repeat (3) tick();
    check_reset_values();
    reset_ni = 1'b1;
    tick();

    // basic 4-sample ramp from 0x10
    run_burst(4, 0, 100, 1'b0, 0, -1, -1, 2, 16'h0010);
    // gapped input
    run_burst(3, 0, 0, 1'b1, 0, -1, -1, 1, 16'h0100);
    // FIFO full on the second slot
    run_burst(4, 0, 100, 1'b0, 0, 1, -1, 0, 16'h0200);
    // decimation by 3 over a ramp from 0
    run_burst(3, 2, 100, 1'b0, 0, -1, -1, 0, 16'h0000);

    // arm with zero length and trigger while idle are both ignored
    arm_i = 1'b1; len_i = '0; trigger_i = 1'b1; s_axis_in.tvalid = 1'b1;
    tick();
    arm_i = 1'b0; trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0; s_axis_in.tvalid = 1'b0;
    check("busy_len0_arm", {31'd0, busy_o}, 0);
    tick();
    check("busy_idle_trigger", {31'd0, busy_o}, 0);

    // reset at slot 2 of 5, then a complete 5-sample burst
    run_burst(5, 0, 100, 1'b0, 0, -1, 2, 1, 16'h0300);
    run_burst(5, 0, 100, 1'b0, 0, -1, -1, 1, 16'h0400);
    // maximum length is accepted; abandoned via reset after a few slots
    run_burst(32'h0000_FFFF, 0, 100, 1'b0, 10, -1, 20, 0, 16'h0500);

    for (int n = 0; n < 40; n++) begin
      run_burst($urandom_range(1, 12), $urandom_range(0, 3), $urandom_range(30, 100), 1'b0,
                $urandom_range(0, 40), -1, -1, $urandom_range(0, 3), DW'($urandom));
    end

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size() + done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axis_burst_capture.md
# axis_burst_capture

Trigger-driven burst capture stage that sits directly upstream of the AXI-lite readable stream FIFO. It watches a continuous sample stream, waits for an arm and then a trigger, and forwards exactly `len_i` samples, optionally decimated, into the FIFO write port. The first sample of a burst is marked in `tuser[0]` and the last in `tlast`. Samples offered while the FIFO reports full are dropped and counted, so software can detect gaps.

## Interface
- `DATA_WIDTH`, 16, sample width.
- `USER_WIDTH`, 1, tuser width; bit 0 is start-of-burst, upper bits are always 0.
- `LEN_WIDTH`, 16, width of burst length.
- `clk_i`  in  1  single clock for the block.
- `reset_ni`  in  1  reset, synchronous, active-low.
- `s_axis_in_tdata`  in  DATA_WIDTH  input sample.
- `s_axis_in_tvalid`  in  1  input sample valid; no backpressure to the source.
- `arm_i`  in  1  level/pulse; arms capture when in IDLE.
- `trigger_i`  in  1  starts burst when ARMED.
- `len_i`  in  LEN_WIDTH  burst length in output samples; latched at arm.
- `decim_i`  in  8  keep 1 of `decim_i+1` samples; latched at arm (see Configuration).
- `m_axis_out_tdata`  out  DATA_WIDTH  sample to FIFO.
- `m_axis_out_tuser`  out  USER_WIDTH  bit 0 = first sample of burst.
- `m_axis_out_tlast`  out  1  last sample of burst.
- `m_axis_out_tvalid`  out  1  write strobe to FIFO.
- `m_axis_out_tfull`  in  1  FIFO full flag.
- `busy_o`  out  1  high in ARMED or CAPTURE.
- `done_o`  out  1  one-cycle pulse at burst end.
- `overflow_cnt_o`  out  16  dropped-sample counter, saturating at 0xFFFF.

## Operation
- States: IDLE, ARMED, CAPTURE.
- IDLE: `arm_i`=1 with `len_i`≠0 → ARMED, latching `len_i` and `decim_i`. `arm_i` with `len_i`=0 is ignored.
- ARMED: `trigger_i`=1 → CAPTURE. The decimation phase counter clears and the sample counter clears. The trigger cycle itself is evaluated as a CAPTURE cycle, so if `s_axis_in_tvalid`=1 in that cycle, it supplies sample 0.
- CAPTURE, per valid input sample:
  - The decimation phase counter selects the sample when it is 0; phase wraps at `decim_i`.
  - A selected sample consumes one slot of the length counter, whether or not it is forwarded.
  - If `m_axis_out_tfull`=0 in that cycle, the sample is emitted. `tuser[0]`=1 when slot index is 0. `tlast`=1 when slot index is `len-1`.
  - If `m_axis_out_tfull`=1, the sample is dropped and `overflow_cnt_o` increments (saturating). A dropped first or last slot loses its marker; there is no retry.
  - After slot `len-1` is consumed: → IDLE, and `done_o` pulses.
- `arm_i` and `trigger_i` are ignored outside IDLE and ARMED respectively; there is no abort. `trigger_i` in IDLE is ignored.
- `overflow_cnt_o` clears only on reset. It is not cleared by arming.
- Width rules:
  - Slot counter is LEN_WIDTH wide and compares against the latched `len-1`.
  - Phase counter is 8 bits.
  - `len_i`=2^LEN_WIDTH−1 is legal.

## Timing
- Reset values: all `m_axis_out_*` = 0, `busy_o`=0, `done_o`=0, `overflow_cnt_o`=0, state IDLE.
- Reset mid-burst: the burst is discarded with no tlast; the same reset values apply the next cycle.
- Output is registered, with one-cycle latency: an input accepted in cycle n appears on `m_axis_out_*` in cycle n+1, with `tvalid` high for exactly one cycle.
- `tfull` is sampled in cycle n, the same cycle as the input. The FIFO must therefore flag full with at least one free entry of margin.
- `done_o` asserts in the same cycle as the output of the final slot, whether it was emitted or dropped. `busy_o` drops in that same cycle.
- Back-to-back bursts: `arm_i` in the cycle after `done_o` is accepted.
- Throughput: one sample per clock.

## Configuration
- Macro: `AXIS_BURST_CAPTURE_DECIMATION_EN`.
- Defined: decimation operates as described, using the latched `decim_i`.
- Undefined: the decimation logic and phase counter are not built. `decim_i` is ignored, and every valid input sample is a slot, as if `decim_i`=0.

## Test plan
- Basic burst:
  - Stimulus: reset; `len_i`=4, arm, trigger with continuous valid ramp 0x10,0x11,… starting at trigger.
  - Required response: output 0x10..0x13 on consecutive cycles. `tuser` is 1,0,0,0 and `tlast` is 0,0,0,1. `done_o` pulses with 0x13. `busy_o` falls.
- Gapped input:
  - Stimulus: `len_i`=3, valid toggling 1,0,1,0,1.
  - Required response: three outputs, each one cycle after its input. `tlast` on the third.
- Overflow:
  - Stimulus: `len_i`=4, `tfull`=1 during the 2nd slot.
  - Required response: outputs are slots 0, 2, 3. `overflow_cnt_o`=1. `tlast` on slot 3.
- Decimation (macro defined):
  - Stimulus: `decim_i`=2, `len_i`=3, ramp 0..8.
  - Required response: outputs 0, 3, 6.
  - With the macro undefined, the same stimulus produces outputs 0, 1, 2.
- Protocol edges:
  - Stimulus: `len_i`=0 arm; trigger while IDLE; re-arm while CAPTURE.
  - Required response: all are ignored, and the state is unchanged.
- Reset mid-burst:
  - Stimulus: assert `reset_ni`=0 at slot 2 of 5.
  - Required response: next cycle all outputs are 0 and state is IDLE. A fresh arm+trigger then produces a full 5-sample burst.
